// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver feeding a first-word-fall-through receive FIFO.
//   Bytes are sampled at mid-bit from a two-flop-synchronised copy of rx.
//   They are queued for the J1 IO read port. Framing errors and overruns
//   are reported as one-cycle pulses.
//
// Parameters
//   CLK_FREQ    clk_in frequency in Hz
//   BAUD        serial line rate
//   FIFO_DEPTH  receive FIFO entries (power of 2, >= 2)
//
// Ports
//   clk_in     in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line, asynchronous, idle high
//   rd_en      in   pop request (ignored while empty)
//   rd_data    out  FIFO head byte, valid while empty=0
//   empty      out  FIFO holds no bytes
//   full       out  FIFO holds FIFO_DEPTH bytes
//   count      out  number of bytes held
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: good byte dropped, FIFO full
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF_BIT - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    DEPTH_L   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_rx_meta;
  logic                r_rx_s;
  logic [BAUD_W-1:0]   r_baud_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                r_frame_err;
  logic                r_overrun;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic                w_half_done;
  logic                w_bit_done;
  logic                w_baud_clr;
  logic                w_sample_bit;
  logic                w_stop_tick;
  logic                w_push;
  logic                w_pop;
  logic                w_can_accept;
  logic                w_ferr;
  logic                w_ovr;

  // Two-flop synchroniser, reset to the idle line level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_half_done = (r_baud_cnt == HALF_LAST);
  assign w_bit_done  = (r_baud_cnt == BIT_LAST);

  // FSM: state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!r_rx_s) w_state_nxt = S_START;
      S_START: if (w_half_done) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      S_STOP:  if (w_bit_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_baud_clr   = 1'b0;
    w_sample_bit = 1'b0;
    w_stop_tick  = 1'b0;
    case (r_state)
      S_IDLE:  w_baud_clr = 1'b1;
      S_START: w_baud_clr = w_half_done;
      S_DATA: begin
        w_baud_clr   = w_bit_done;
        w_sample_bit = w_bit_done;
      end
      S_STOP: begin
        w_baud_clr  = w_bit_done;
        w_stop_tick = w_bit_done;
      end
      default: w_baud_clr = 1'b1;
    endcase
  end

  // A full FIFO still accepts a byte when the head is popped on the same edge.
  assign w_pop        = rd_en && (r_count != '0);
  assign w_can_accept = (r_count != DEPTH_L) || w_pop;
  assign w_push       = w_stop_tick &&  r_rx_s &&  w_can_accept;
  assign w_ovr        = w_stop_tick &&  r_rx_s && !w_can_accept;
  assign w_ferr       = w_stop_tick && !r_rx_s;

  // Receiver datapath: baud counter, bit index, shift register, flag pulses.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_baud_clr) r_baud_cnt <= '0;
      else            r_baud_cnt <= r_baud_cnt + 1'b1;

      if (r_state == S_START) r_bit_idx <= '0;
      else if (w_sample_bit)  r_bit_idx <= r_bit_idx + 1'b1;

      if (w_sample_bit) r_shift[r_bit_idx] <= r_rx_s;

      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
    end
  end

  // Receive FIFO. Storage is reset so rd_data reads zero out of reset.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data   = r_mem[r_rd_ptr];
  assign empty     = (r_count == '0);
  assign full      = (r_count == DEPTH_L);
  assign count     = r_count;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule
